// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 key controller: FSM states,
// prefix/ignored scancodes and the key_down bit map.
package ps2_pkg;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    // Encoding is {ext, brk} so the pending prefixes read straight off the state.
    typedef enum logic [1:0] {
        DEC_BASE    = 2'b00,
        DEC_BRK     = 2'b01,
        DEC_EXT     = 2'b10,
        DEC_EXT_BRK = 2'b11
    } dec_state_t;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    localparam logic [7:0] CODE_LEFT    = 8'h6B;
    localparam logic [7:0] CODE_RIGHT   = 8'h74;
    localparam logic [7:0] CODE_UP      = 8'h75;
    localparam logic [7:0] CODE_DOWN    = 8'h72;
    localparam logic [7:0] CODE_SHIFT_L = 8'h12;
    localparam logic [7:0] CODE_SHIFT_R = 8'h59;
    localparam logic [7:0] CODE_Z       = 8'h1A;
    localparam logic [7:0] CODE_X       = 8'h22;
    localparam logic [7:0] CODE_R       = 8'h2D;

    localparam logic [3:0] KEY_LEFT    = 4'd0;
    localparam logic [3:0] KEY_RIGHT   = 4'd1;
    localparam logic [3:0] KEY_UP      = 4'd2;
    localparam logic [3:0] KEY_DOWN    = 4'd3;
    localparam logic [3:0] KEY_SHIFT   = 4'd4;
    localparam logic [3:0] KEY_Z       = 4'd5;
    localparam logic [3:0] KEY_X       = 4'd6;
    localparam logic [3:0] KEY_R       = 4'd7;
    // Right shift keeps its own flag so releasing one shift key leaves the other held.
    localparam logic [3:0] KEY_SHIFT_R = 4'd8;
    localparam int         KEY_FLAGS   = 9;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_map_t;

    function automatic logic is_ignored(input logic [7:0] code);
        case (code)
            8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic key_map_t key_lookup(input logic [7:0] code, input logic ext);
        key_map_t m;
        m = '{hit: 1'b0, idx: 4'd0};
        if (ext) begin
            case (code)
                CODE_LEFT:  m = '{hit: 1'b1, idx: KEY_LEFT};
                CODE_RIGHT: m = '{hit: 1'b1, idx: KEY_RIGHT};
                CODE_UP:    m = '{hit: 1'b1, idx: KEY_UP};
                CODE_DOWN:  m = '{hit: 1'b1, idx: KEY_DOWN};
                default:    m = '{hit: 1'b0, idx: 4'd0};
            endcase
        end else begin
            case (code)
                CODE_SHIFT_L: m = '{hit: 1'b1, idx: KEY_SHIFT};
                CODE_SHIFT_R: m = '{hit: 1'b1, idx: KEY_SHIFT_R};
                CODE_Z:       m = '{hit: 1'b1, idx: KEY_Z};
                CODE_X:       m = '{hit: 1'b1, idx: KEY_X};
                CODE_R:       m = '{hit: 1'b1, idx: KEY_R};
                default:      m = '{hit: 1'b0, idx: 4'd0};
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pad synchronisers, glitch filters, clk-domain frame FSM and
// inactivity timeout. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
    output logic       err_o
);

    localparam int            TW   = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    logic [1:0]            c_sync_q, d_sync_q;
    logic [FILTER_LEN-1:0] c_shift_q, d_shift_q;
    logic                  c_filt_q, d_filt_q;
    logic                  c_filt_d, d_filt_d;
    logic                  fall;
    logic                  parity_ok;

    frame_state_t          state_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            shift_q;
    logic [TW-1:0]         tcnt_q;
    logic                  byte_vld_q;
    logic [7:0]            byte_q;
    logic                  err_q;

    // NOTE: idle PS/2 lines are high, so every stage resets to 1 to avoid a fake fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_sync_q  <= 2'b11;
            d_sync_q  <= 2'b11;
            c_shift_q <= '1;
            d_shift_q <= '1;
            c_filt_q  <= 1'b1;
            d_filt_q  <= 1'b1;
        end else begin
            c_sync_q  <= {c_sync_q[0], ps2_clk_i};
            d_sync_q  <= {d_sync_q[0], ps2_data_i};
            c_shift_q <= {c_shift_q[FILTER_LEN-2:0], c_sync_q[1]};
            d_shift_q <= {d_shift_q[FILTER_LEN-2:0], d_sync_q[1]};
            c_filt_q  <= c_filt_d;
            d_filt_q  <= d_filt_d;
        end
    end

    always_comb begin
        c_filt_d = c_filt_q;
        d_filt_d = d_filt_q;
        if (&c_shift_q)       c_filt_d = 1'b1;
        else if (~|c_shift_q) c_filt_d = 1'b0;
        if (&d_shift_q)       d_filt_d = 1'b1;
        else if (~|d_shift_q) d_filt_d = 1'b0;
    end

    assign fall = c_filt_q & ~c_filt_d;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q;
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FR_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tcnt_q     <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= 8'h00;
            err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
            if (fall) begin
                tcnt_q <= '0;
                case (state_q)
                    FR_IDLE: begin
                        if (!d_filt_q) begin
                            state_q   <= FR_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    FR_DATA: begin
                        shift_q <= {d_filt_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) state_q <= FR_PARITY;
                        else                   bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    FR_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_q <= d_filt_q;
`endif
                        state_q  <= FR_STOP;
                    end
                    FR_STOP: begin
                        state_q <= FR_IDLE;
                        if (d_filt_q && parity_ok) begin
                            byte_vld_q <= 1'b1;
                            byte_q     <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: state_q <= FR_IDLE;
                endcase
            end else if (state_q != FR_IDLE) begin
                // A stalled partial frame is abandoned so the next start bit resyncs.
                if (tcnt_q == TMAX) begin
                    state_q <= FR_IDLE;
                    err_q   <= 1'b1;
                    tcnt_q  <= '0;
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end
        end
    end

    assign byte_vld_o = byte_vld_q;
    assign byte_o     = byte_q;
    assign err_o      = err_q;

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key controller top: prefix decode, one-entry event register and key_down bitmap.
// Define PS2_PARITY_CHECK_EN to enable parity rejection in the frame receiver.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ev_ready,
    input  logic       clr_err,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic [7:0] key_down,
    output logic       frame_err,
    output logic       overflow
);

    logic       byte_vld;
    logic [7:0] byte_data;
    logic       rx_err;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .byte_vld_o (byte_vld),
        .byte_o     (byte_data),
        .err_o      (rx_err)
    );

    dec_state_t           dec_q;
    key_event_t           ev_q;
    logic                 ev_valid_q;
    logic                 frame_err_q;
    logic                 overflow_q;
    logic [KEY_FLAGS-1:0] keys_q;

    logic                 pend_ext, pend_brk;
    logic                 new_ev;
    logic                 drop;
    key_event_t           ev_d;
    key_map_t             map;

    assign pend_ext = dec_q[1];
    assign pend_brk = dec_q[0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        new_ev = 1'b0;
        ev_d   = '{code: byte_data, ext: pend_ext, brk: pend_brk};
        if (byte_vld && byte_data != CODE_EXT && byte_data != CODE_BRK
                && !is_ignored(byte_data)) begin
            new_ev = 1'b1;
        end
        map  = key_lookup(byte_data, pend_ext);
        drop = new_ev & ev_valid_q & ~ev_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= DEC_BASE;
        end else if (byte_vld) begin
            if (byte_data == CODE_EXT)      dec_q <= pend_brk ? DEC_EXT_BRK : DEC_EXT;
            else if (byte_data == CODE_BRK) dec_q <= pend_ext ? DEC_EXT_BRK : DEC_BRK;
            else                            dec_q <= DEC_BASE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_valid_q <= 1'b0;
            ev_q       <= '0;
        end else if (new_ev && (!ev_valid_q || ev_ready)) begin
            ev_valid_q <= 1'b1;
            ev_q       <= ev_d;
        end else if (ev_ready) begin
            ev_valid_q <= 1'b0;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (rx_err)       frame_err_q <= 1'b1;
            else if (clr_err) frame_err_q <= 1'b0;
            if (drop)         overflow_q  <= 1'b1;
            else if (clr_err) overflow_q  <= 1'b0;
        end
    end

    // Key state follows every decoded event, including ones the event register dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_q <= '0;
        end else if (new_ev && map.hit) begin
            keys_q[map.idx] <= ~pend_brk;
        end
    end

    assign ev_valid  = ev_valid_q;
    assign ev_code   = ev_q.code;
    assign ev_ext    = ev_q.ext;
    assign ev_brk    = ev_q.brk;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign key_down  = {keys_q[KEY_R], keys_q[KEY_X], keys_q[KEY_Z],
                        keys_q[KEY_SHIFT] | keys_q[KEY_SHIFT_R],
                        keys_q[KEY_DOWN], keys_q[KEY_UP], keys_q[KEY_RIGHT], keys_q[KEY_LEFT]};

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: frames are bit-banged on the pads with a
// 40-clk PS/2 bit period; expected values are hand-computed per step.
module tb_ps2_key_ctrl;

    localparam int TO_CYC = 400;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ev_ready;
    logic       clr_err;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic [7:0] key_down;
    logic       frame_err;
    logic       overflow;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int exp_acc = 0;

    int         acc_cnt = 0;
    logic [7:0] acc_code = 8'h00;
    logic       acc_ext = 1'b0;
    logic       acc_brk = 1'b0;

    ps2_key_ctrl #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev_ready  (ev_ready),
        .clr_err   (clr_err),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_brk    (ev_brk),
        .key_down  (key_down),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    // Posedges fall at 8 mod 10 so stimulus on multiples of 10 stays off the edges.
    initial begin
        clk = 1'b0;
        #3;
        forever #5 clk = ~clk;
    end

    // Record each handshake on the falling edge ahead of the accepting posedge.
    always @(negedge clk) begin
        if (ev_valid && ev_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_code <= ev_code;
            acc_ext  <= ev_ext;
            acc_brk  <= ev_brk;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #100;
        ps2_clk = 1'b0;
        #200;
        ps2_clk = 1'b1;
        #100;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        #300;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        #10;
        clr_err = 1'b0;
        #20;
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ev_ready = 1'b1;
        clr_err  = 1'b0;
        #50;
        check("reset_outputs", {ev_valid, ev_code, ev_ext, ev_brk, key_down, frame_err, overflow}, 32'h0);
        rst = 1'b0;
        #100;

        // 1: Z make, then Z break
        send(8'h1A); exp_acc = 1;
        check("z_make_cnt", acc_cnt, exp_acc);
        check("z_make_code", {acc_code, acc_ext, acc_brk}, {8'h1A, 2'b00});
        check("z_make_keys", key_down, 8'h20);
        check("z_make_valid_gone", ev_valid, 1'b0);
        check("z_make_err", frame_err, 1'b0);
        send(8'hF0); send(8'h1A); exp_acc = 2;
        check("z_brk_cnt", acc_cnt, exp_acc);
        check("z_brk_code", {acc_code, acc_ext, acc_brk}, {8'h1A, 2'b01});
        check("z_brk_keys", key_down, 8'h00);

        // 2: extended LEFT, keypad 6B does not touch the LEFT bit
        send(8'hE0); send(8'h6B); exp_acc = 3;
        check("left_make_cnt", acc_cnt, exp_acc);
        check("left_make_code", {acc_code, acc_ext, acc_brk}, {8'h6B, 2'b10});
        check("left_make_keys", key_down, 8'h01);
        send(8'hF0); send(8'h6B); exp_acc = 4;
        check("kp_brk_code", {acc_code, acc_ext, acc_brk}, {8'h6B, 2'b01});
        check("kp_brk_keys", key_down, 8'h01);
        send(8'h6B); exp_acc = 5;
        check("kp_make_code", {acc_code, acc_ext, acc_brk}, {8'h6B, 2'b00});
        check("kp_make_keys", key_down, 8'h01);
        send(8'hE0); send(8'hF0); send(8'h6B); exp_acc = 6;
        check("left_brk_cnt", acc_cnt, exp_acc);
        check("left_brk_code", {acc_code, acc_ext, acc_brk}, {8'h6B, 2'b11});
        check("left_brk_keys", key_down, 8'h00);

        // 3: back-pressure, overflow, single accept, clr_err
        ev_ready = 1'b0;
        send(8'h22);
        check("hold_valid", ev_valid, 1'b1);
        check("hold_code", {ev_code, ev_ext, ev_brk}, {8'h22, 2'b00});
        check("hold_ovf_clear", overflow, 1'b0);
        check("hold_keys", key_down, 8'h40);
        send(8'h2D);
        check("ovf_code_stable", {ev_valid, ev_code}, {1'b1, 8'h22});
        check("ovf_flag", overflow, 1'b1);
        check("ovf_keys", key_down, 8'hC0);
        check("ovf_no_accept", acc_cnt, exp_acc);
        ev_ready = 1'b1;
        #50;
        exp_acc = 7;
        check("one_accept_cnt", acc_cnt, exp_acc);
        check("one_accept_code", acc_code, 8'h22);
        check("one_accept_valid", ev_valid, 1'b0);
        pulse_clr();
        check("ovf_cleared", overflow, 1'b0);
        send(8'hF0); send(8'h22);
        send(8'hF0); send(8'h2D); exp_acc = 9;
        check("xr_release_cnt", acc_cnt, exp_acc);
        check("xr_release_keys", key_down, 8'h00);

        // 4: bad stop bit
        send_frame(8'h1A, 1'b0, 1'b0);
        check("badstop_cnt", acc_cnt, exp_acc);
        check("badstop_err", frame_err, 1'b1);
        check("badstop_keys", key_down, 8'h00);
        send(8'h1A); exp_acc = 10;
        check("after_badstop_cnt", acc_cnt, exp_acc);
        check("after_badstop_code", {acc_code, acc_ext, acc_brk}, {8'h1A, 2'b00});
        check("after_badstop_err_sticky", frame_err, 1'b1);
        pulse_clr();
        check("err_cleared", frame_err, 1'b0);
        send(8'hF0); send(8'h1A); exp_acc = 11;
        check("z_release_keys", key_down, 8'h00);

        // 5: timeout after 4 data bits
        ps2_bit(1'b0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_data = 1'b1;
        #((TO_CYC + 50) * 10);
        check("timeout_err", frame_err, 1'b1);
        check("timeout_cnt", acc_cnt, exp_acc);
        pulse_clr();
        send(8'h29); exp_acc = 12;
        check("after_timeout_cnt", acc_cnt, exp_acc);
        check("after_timeout_code", {acc_code, acc_ext, acc_brk}, {8'h29, 2'b00});
        check("after_timeout_err", frame_err, 1'b0);

        // 6: bad parity on 1A
        send_frame(8'h1A, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("badpar_cnt", acc_cnt, exp_acc);
        check("badpar_err", frame_err, 1'b1);
        check("badpar_keys", key_down, 8'h00);
        pulse_clr();
`else
        exp_acc = 13;
        check("badpar_cnt", acc_cnt, exp_acc);
        check("badpar_code", acc_code, 8'h1A);
        check("badpar_err", frame_err, 1'b0);
        check("badpar_keys", key_down, 8'h20);
        send(8'hF0); send(8'h1A); exp_acc = 14;
        check("badpar_release_keys", key_down, 8'h00);
`endif

        // Reset in the middle of a frame with state built up everywhere
        ev_ready = 1'b0;
        send(8'h22);
        send(8'h2D);
        check("pre_rst_state", {ev_valid, overflow, key_down}, {1'b1, 1'b1, 8'hC0});
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        ps2_data = 1'b1;
        rst = 1'b1;
        #20;
        check("mid_rst_outputs", {ev_valid, ev_code, ev_ext, ev_brk, key_down, frame_err, overflow}, 32'h0);
        rst = 1'b0;
        #100;
        ev_ready = 1'b1;
        send(8'h1A); exp_acc = exp_acc + 1;
        check("post_rst_cnt", acc_cnt, exp_acc);
        check("post_rst_code", {acc_code, acc_ext, acc_brk}, {8'h1A, 2'b00});
        check("post_rst_keys", key_down, 8'h20);
        check("post_rst_err", frame_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
